// File: rtl/str_unpack.sv
// Unpacks a left-NUL-padded packed string word into a stream of ASCII bytes,
// most significant character first, one beat per character.
module str_unpack #(
  parameter int WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        out_char,
  output logic                              out_last,
  output logic                              out_empty,
  output logic [$clog2(WIDTH/8+1)-1:0]      out_len
);

  localparam int NCHAR = WIDTH / 8;
  localparam int LEN_W = $clog2(NCHAR + 1);
  localparam int IDX_W = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(NCHAR);
  localparam logic [LEN_W-1:0] LZ_LAST  = LEN_W'(NCHAR - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHAR - 1);

  generate
    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("str_unpack: WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt;
  logic [LEN_W-1:0] in_lz;

  // Number of NUL bytes before the first character, scanning from the MS end.
  function automatic logic [LEN_W-1:0] count_lz(input logic [WIDTH-1:0] d);
    logic [LEN_W-1:0] n;
    logic             seen;
    n    = '0;
    seen = 1'b0;
    for (int i = 0; i < NCHAR; i++) begin
      if (!seen && d[WIDTH-1-8*i -: 8] == 8'h00) n = n + LEN_W'(1);
      else seen = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [WIDTH-1:0] d,
                                           input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] s;
    s = d << (8 * idx);
    return s[WIDTH-1 -: 8];
  endfunction

  assign in_lz   = count_lz(in_data);
  assign idx_nxt = idx_r + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      out_empty <= 1'b0;
      out_len   <= '0;
      idx_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_r    <= in_data;
            out_len   <= LEN_FULL - in_lz;
            state     <= EMIT;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            // An all-NUL word still produces one terminating beat.
            if (in_lz == LEN_FULL) begin
              idx_r     <= IDX_LAST;
              out_char  <= 8'h00;
              out_last  <= 1'b1;
              out_empty <= 1'b1;
            end else begin
              idx_r     <= IDX_W'(in_lz);
              out_char  <= pick_byte(in_data, IDX_W'(in_lz));
              out_last  <= (in_lz == LZ_LAST);
              out_empty <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_empty <= 1'b0;
            end else begin
              idx_r    <= idx_nxt;
              out_char <= pick_byte(data_r, idx_nxt);
              out_last <= (idx_nxt == IDX_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_str_unpack.sv
// Bench for str_unpack: directed and random words on a 32-bit and a 16-bit
// instance, compared against a byte-list model of the packed string.
module tb_str_unpack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel16;
  logic        drv_valid;
  logic [31:0] drv_data;
  logic        drv_ready;

  logic       in_ready32, out_valid32, out_last32, out_empty32;
  logic [7:0] out_char32;
  logic [2:0] out_len32;
  logic       in_ready16, out_valid16, out_last16, out_empty16;
  logic [7:0] out_char16;
  logic [1:0] out_len16;

  logic       ob_ready, ob_valid, ob_last, ob_empty;
  logic [7:0] ob_char;
  logic [2:0] ob_len;

  int checks   = 0;
  int failures = 0;

  str_unpack #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(drv_valid & ~sel16), .in_ready(in_ready32), .in_data(drv_data),
    .out_valid(out_valid32), .out_ready(drv_ready), .out_char(out_char32),
    .out_last(out_last32), .out_empty(out_empty32), .out_len(out_len32)
  );

  str_unpack #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(drv_valid & sel16), .in_ready(in_ready16), .in_data(drv_data[15:0]),
    .out_valid(out_valid16), .out_ready(drv_ready), .out_char(out_char16),
    .out_last(out_last16), .out_empty(out_empty16), .out_len(out_len16)
  );

  always_comb begin
    ob_ready = sel16 ? in_ready16  : in_ready32;
    ob_valid = sel16 ? out_valid16 : out_valid32;
    ob_last  = sel16 ? out_last16  : out_last32;
    ob_empty = sel16 ? out_empty16 : out_empty32;
    ob_char  = sel16 ? out_char16  : out_char32;
    ob_len   = sel16 ? {1'b0, out_len16} : out_len32;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 = always ready, 1 = ready toggles 1/0, 2 = random ready
  task automatic run_word(input logic [31:0] w, input int nchar, input int rmode);
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int lz, len, k, cyc;
    logic empty;
    exp_q = {};
    lz = 0;
    for (int i = 0; i < nchar; i++) begin
      b = 8'(w >> (8 * (nchar - 1 - i)));
      if (exp_q.size() == 0 && b == 8'h00) lz++;
      else exp_q.push_back(b);
    end
    len   = nchar - lz;
    empty = (len == 0);
    if (empty) exp_q.push_back(8'h00);

    @(negedge clk);
    chk("idle_in_ready", 32'(ob_ready), 32'd1);
    chk("idle_out_valid", 32'(ob_valid), 32'd0);
    drv_valid = 1'b1;
    drv_data  = w;
    @(negedge clk);
    drv_valid = 1'b0;
    drv_data  = $urandom;
    k   = 0;
    cyc = 0;
    while (k < exp_q.size() && cyc < 100) begin
      chk("beat_valid", 32'(ob_valid), 32'd1);
      chk("beat_in_ready", 32'(ob_ready), 32'd0);
      chk("beat_char", 32'(ob_char), 32'(exp_q[k]));
      chk("beat_last", 32'(ob_last), 32'(k == exp_q.size() - 1));
      chk("beat_empty", 32'(ob_empty), 32'(empty));
      chk("beat_len", 32'(ob_len), 32'(len));
      if (rmode == 0)      drv_ready = 1'b1;
      else if (rmode == 1) drv_ready = (cyc % 2 == 0);
      else                 drv_ready = 1'($urandom_range(0, 1));
      if (drv_ready) k++;
      drv_data = $urandom;
      @(negedge clk);
      cyc++;
    end
    if (k < exp_q.size()) chk("beat_timeout", 32'(k), 32'(exp_q.size()));
    chk("done_out_valid", 32'(ob_valid), 32'd0);
    chk("done_in_ready", 32'(ob_ready), 32'd1);
    drv_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_word(input int nchar);
    logic [31:0] w;
    int lzr;
    w   = $urandom;
    lzr = $urandom_range(0, nchar);
    for (int i = 0; i < nchar; i++) begin
      if (i < lzr || $urandom_range(0, 3) == 0)
        w = w & ~(32'hFF << (8 * (nchar - 1 - i)));
    end
    if (nchar < 4) w = w & ((32'd1 << (8 * nchar)) - 1);
    return w;
  endfunction

  initial begin
    rst       = 1'b1;
    sel16     = 1'b0;
    drv_valid = 1'b1;
    drv_data  = 32'h00666F6F;
    drv_ready = 1'b1;

    // Reset held with in_valid high: nothing may be accepted.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(ob_valid), 32'd0);
    chk("rst_in_ready", 32'(ob_ready), 32'd1);
    chk("rst_out_char", 32'(ob_char), 32'd0);
    chk("rst_out_last", 32'(ob_last), 32'd0);
    chk("rst_out_empty", 32'(ob_empty), 32'd0);
    chk("rst_out_len", 32'(ob_len), 32'd0);
    rst       = 1'b0;
    drv_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(ob_valid), 32'd0);

    run_word(32'h00666F6F, 4, 0);
    run_word(32'h00626172, 4, 1);
    run_word(32'h00000000, 4, 0);
    run_word(32'h41004200, 4, 0);
    run_word(32'h12345678, 4, 2);

    // Reset after the first beat of "foo" aborts the word.
    @(negedge clk);
    drv_valid = 1'b1;
    drv_data  = 32'h00666F6F;
    drv_ready = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
    chk("abort_first_char", 32'(ob_char), 32'h66);
    @(negedge clk);
    chk("abort_second_char", 32'(ob_char), 32'h6F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 32'(ob_valid), 32'd0);
    chk("abort_in_ready", 32'(ob_ready), 32'd1);
    chk("abort_out_char", 32'(ob_char), 32'd0);
    chk("abort_out_len", 32'(ob_len), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_beats", 32'(ob_valid), 32'd0);
    end
    run_word(32'h00626172, 4, 0);

    sel16 = 1'b1;
    run_word(32'h00006F6F, 2, 0);
    run_word(32'h00000041, 2, 1);
    run_word(32'h00000000, 2, 0);

    for (int n = 0; n < 15; n++) begin
      sel16 = 1'b0;
      run_word(rand_word(4), 4, 2);
      sel16 = 1'b1;
      run_word(rand_word(2), 2, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
